// File: rtl/reg_access_ctrl.sv
// Operand-fetch / execute / writeback sequencer sitting in front of a small register file.
// Define RACTL_TIMEOUT_EN to compile in an EXEC watchdog that aborts after TIMEOUT_CYC cycles.
//   state  | meaning
//   IDLE   | waiting for start
//   RD_A   | reading operand A (readnum = rn_q)
//   RD_B   | reading operand B (readnum = rm_q)
//   EXEC   | operands valid, waiting for result_valid
//   WB     | writing result to rd_q
//   DONE   | one-cycle completion pulse
module reg_access_ctrl #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_rn,
  input  logic [2:0]        i_rm,
  input  logic [2:0]        i_rd,
  input  logic              i_wb_en,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_result_valid,
  input  logic [DATA_W-1:0] i_data_out,
  output logic [2:0]        o_readnum,
  output logic [2:0]        o_writenum,
  output logic              o_write,
  output logic [DATA_W-1:0] o_data_in,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              o_ops_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_rn_q;
  logic [2:0]        r_rm_q;
  logic [2:0]        r_rd_q;
  logic              r_wb_q;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_data_in;
  logic              w_timeout;

  // Degenerate limits are not meaningful; this also keeps the parameter referenced in both builds.
  if (TIMEOUT_CYC < 1) begin : g_timeout_range
  end

`ifdef RACTL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_exec_cnt;
  logic             r_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_exec_cnt <= '0;
    end else if (r_state != S_EXEC) begin
      r_exec_cnt <= '0;
    end else if (!i_result_valid) begin
      r_exec_cnt <= r_exec_cnt + 1'b1;
    end
  end

  // Fires on the cycle whose stall would bring the count to the limit; a result that cycle wins.
  assign w_timeout = (r_state == S_EXEC) && !i_result_valid &&
                     (r_exec_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err && (r_state == S_DONE);
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RD_A;
      S_RD_A: w_next = S_RD_B;
      S_RD_B: w_next = S_EXEC;
      S_EXEC: begin
        if (i_result_valid) begin
          w_next = r_wb_q ? S_WB : S_DONE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_WB:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rn_q    <= '0;
      r_rm_q    <= '0;
      r_rd_q    <= '0;
      r_wb_q    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_data_in <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rn_q <= i_rn;
            r_rm_q <= i_rm;
            r_rd_q <= i_rd;
            r_wb_q <= i_wb_en;
          end
        end
        S_RD_A: r_a <= i_data_out;
        S_RD_B: r_b <= i_data_out;
        S_EXEC: if (i_result_valid) r_data_in <= i_result;
        default: ;
      endcase
    end
  end

  assign o_readnum   = (r_state == S_RD_B) ? r_rm_q : r_rn_q;
  assign o_writenum  = r_rd_q;
  assign o_write     = (r_state == S_WB);
  assign o_data_in   = r_data_in;
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_ops_valid = (r_state == S_EXEC);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: register-file model plus cycle-indexed reference expectations.
module tb_reg_access_ctrl;

  localparam int DW     = 16;
  localparam int TO_CYC = 4;
`ifdef RACTL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, wb_en, result_valid;
  logic [2:0]    rn, rm, rd, readnum, writenum;
  logic [DW-1:0] result, data_out, data_in, a, b;
  logic          write, ops_valid, busy, done, err;

  logic [DW-1:0] rf  [8];
  logic [DW-1:0] mdl [8];
  logic          pre_en;
  logic [2:0]    pre_addr;
  logic [DW-1:0] pre_data;
  int            n_writes = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  reg_access_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_rn(rn), .i_rm(rm), .i_rd(rd), .i_wb_en(wb_en),
    .i_result(result), .i_result_valid(result_valid), .i_data_out(data_out),
    .o_readnum(readnum), .o_writenum(writenum), .o_write(write), .o_data_in(data_in),
    .o_a(a), .o_b(b), .o_ops_valid(ops_valid), .o_busy(busy), .o_done(done), .o_err(err)
  );

  assign data_out = rf[readnum];

  always @(posedge clk) begin
    if (write) begin
      rf[writenum] <= data_in;
      n_writes     <= n_writes + 1;
    end else if (pre_en) begin
      rf[pre_addr] <= pre_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic set_reg(input logic [2:0] addr, input logic [DW-1:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = addr; pre_data = val;
    mdl[addr] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One operation; expectations indexed by cycle k after the accepting edge (k=1 is RD_A).
  task automatic run_op(input logic [2:0] op_rn, input logic [2:0] op_rm, input logic [2:0] op_rd,
                        input logic op_wb, input logic [DW-1:0] op_res, input int d, input bit glitch);
    bit to, exp_wr;
    int exec_last, wb_idx, e, w0;
    logic [DW-1:0] ea, eb;
    to        = TO_EN && (d >= TO_CYC);
    exec_last = to ? (2 + TO_CYC) : (3 + d);
    exp_wr    = op_wb && !to;
    wb_idx    = exp_wr ? exec_last + 1 : -1;
    e         = exec_last + 1 + (exp_wr ? 1 : 0);
    ea = mdl[op_rn];
    eb = mdl[op_rm];
    w0 = n_writes;
    @(negedge clk);
    start = 1'b1; rn = op_rn; rm = op_rm; rd = op_rd; wb_en = op_wb;
    result_valid = 1'b0; result = DW'($urandom);
    @(posedge clk);
    for (int k = 1; k <= e + 2; k++) begin
      @(negedge clk);
      total++; if (busy !== (k <= e)) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, (k <= e)); end
      total++; if (ops_valid !== (k >= 3 && k <= exec_last)) begin bad++; $display("FAIL ops_valid k=%0d got=%b exp=%b", k, ops_valid, (k >= 3 && k <= exec_last)); end
      total++; if (write !== (k == wb_idx)) begin bad++; $display("FAIL write k=%0d got=%b exp=%b", k, write, (k == wb_idx)); end
      total++; if (done !== (k == e)) begin bad++; $display("FAIL done k=%0d got=%b exp=%b", k, done, (k == e)); end
      total++; if (err !== ((k == e) && to)) begin bad++; $display("FAIL err k=%0d got=%b exp=%b", k, err, ((k == e) && to)); end
      total++; if (readnum !== ((k == 2) ? op_rm : op_rn)) begin bad++; $display("FAIL readnum k=%0d got=%0d exp=%0d", k, readnum, ((k == 2) ? op_rm : op_rn)); end
      total++; if (writenum !== op_rd) begin bad++; $display("FAIL writenum k=%0d got=%0d exp=%0d", k, writenum, op_rd); end
      if (k >= 2) begin
        total++; if (a !== ea) begin bad++; $display("FAIL opA k=%0d got=%h exp=%h", k, a, ea); end
      end
      if (k >= 3) begin
        total++; if (b !== eb) begin bad++; $display("FAIL opB k=%0d got=%h exp=%h", k, b, eb); end
      end
      if (k == wb_idx) begin
        total++; if (data_in !== op_res) begin bad++; $display("FAIL data_in k=%0d got=%h exp=%h", k, data_in, op_res); end
      end
      start = glitch && (k == 2 || k == 3);
      if (start) begin
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom); wb_en = 1'b1;
      end
      if (k == 3 + d) begin
        result_valid = 1'b1; result = op_res;
      end else if (k >= 3 && k <= exec_last) begin
        result_valid = 1'b0; result = DW'($urandom);
      end else begin
        result_valid = 1'($urandom_range(0, 1)); result = DW'($urandom);
      end
    end
    start = 1'b0; result_valid = 1'b0;
    total++; if ((n_writes - w0) !== (exp_wr ? 1 : 0)) begin bad++; $display("FAIL write_count got=%0d exp=%0d", n_writes - w0, (exp_wr ? 1 : 0)); end
    if (exp_wr) mdl[op_rd] = op_res;
    total++; if (rf[op_rd] !== mdl[op_rd]) begin bad++; $display("FAIL rf_dest r%0d got=%h exp=%h", op_rd, rf[op_rd], mdl[op_rd]); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({readnum, writenum, write, ops_valid, busy, done, err} !== 11'd0) begin bad++; $display("FAIL reset_ctl got=%h exp=0", {readnum, writenum, write, ops_valid, busy, done, err}); end
    total++; if ({a, b, data_in} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {a, b, data_in}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    set_reg(3'd2, 16'h1234);
    set_reg(3'd5, 16'h00FF);
    set_reg(3'd7, 16'h7777);
    run_op(3'd2, 3'd5, 3'd7, 1'b1, 16'h1333, 0, 1'b0);
    set_reg(3'd7, 16'h7777);
    run_op(3'd2, 3'd5, 3'd7, 1'b0, 16'h1333, 0, 1'b0);
    total++; if (rf[7] !== 16'h7777) begin bad++; $display("FAIL r7_unchanged got=%h exp=7777", rf[7]); end
  endtask

  task automatic test_alias();
    set_reg(3'd3, 16'h0A0A);
    run_op(3'd3, 3'd3, 3'd3, 1'b1, 16'hFFFF, 0, 1'b0);
    total++; if (rf[3] !== 16'hFFFF) begin bad++; $display("FAIL r3_alias got=%h exp=ffff", rf[3]); end
  endtask

  task automatic test_start_ignored();
    run_op(3'd2, 3'd5, 3'd6, 1'b1, 16'h5A5A, 1, 1'b1);
    run_op(3'd6, 3'd2, 3'd1, 1'b1, 16'hC3C3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(3'd1, 3'd2, 3'd4, 1'b1, 16'hABCD, 3, 1'b0);
    run_op(3'd1, 3'd2, 3'd4, 1'b1, 16'h4321, 20, 1'b0);
    run_op(3'd4, 3'd4, 3'd0, 1'b0, 16'h0F0F, TO_CYC, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    int w0;
    logic [DW-1:0] old;
    w0  = n_writes;
    old = mdl[3];
    @(negedge clk);
    start = 1'b1; rn = 3'd1; rm = 3'd2; rd = 3'd3; wb_en = 1'b1; result_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (ops_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_exec got=%b exp=1", ops_valid); end
    result_valid = 1'b1; result = 16'hBEEF; reset = 1'b1;
    #1;
    total++; if ({readnum, writenum, write, ops_valid, busy, done, err} !== 11'd0) begin bad++; $display("FAIL midreset_ctl got=%h exp=0", {readnum, writenum, write, ops_valid, busy, done, err}); end
    total++; if ({a, b, data_in} !== '0) begin bad++; $display("FAIL midreset_data got=%h exp=0", {a, b, data_in}); end
    @(negedge clk);
    reset = 1'b0; result_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_midreset got=%b exp=0", busy); end
    total++; if (n_writes !== w0) begin bad++; $display("FAIL midreset_writes got=%0d exp=%0d", n_writes, w0); end
    total++; if (rf[3] !== old) begin bad++; $display("FAIL midreset_r3 got=%h exp=%h", rf[3], old); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_op(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
             DW'($urandom), int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; rd = '0; wb_en = 1'b0;
    result = '0; result_valid = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 8; i++) set_reg(3'(i), DW'($urandom));
    test_reset();
    test_basic();
    test_alias();
    test_start_ignored();
    test_timeout();
    test_reset_mid_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
